// File: rtl/seg_scroll_disp.sv
// seg_scroll_disp: eight-digit multiplexed seven-segment driver.
// Static ID view, blinking-cursor edit view and a timed scrolling marquee.
module seg_scroll_disp #(
   parameter int SCAN_DIV    = 50000,
   parameter int SCROLL_DIV  = 16666667,
   parameter int BLINK_DIV   = 12500000,
   parameter int SCROLL_LAPS = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] disp_data,
   input  logic        disp_data_en,
   input  logic        edit_mode,
   input  logic [3:0]  weishu,
   input  logic [3:0]  shuzi,
   output logic [7:0]  an,
   output logic [7:0]  seg,
   output logic        busy
);

   localparam int STEPS = SCROLL_LAPS * 16;
   localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int SRW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
   localparam int BLW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam int STW = $clog2(STEPS + 1);

   localparam logic [SCW-1:0] SCAN_MAX   = SCW'(SCAN_DIV - 1);
   localparam logic [SRW-1:0] SCROLL_MAX = SRW'(SCROLL_DIV - 1);
   localparam logic [BLW-1:0] BLINK_MAX  = BLW'(BLINK_DIV - 1);
   localparam logic [STW-1:0] STEP_LAST  = STW'(STEPS - 1);

   localparam logic [0:0] ST_NORMAL = 1'b0;
   localparam logic [0:0] ST_SCROLL = 1'b1;

   logic [0:0]     state;
   logic           en_q;
   logic [31:0]    snap;
   logic [SCW-1:0] scan_cnt;
   logic [2:0]     idx;
   logic [SRW-1:0] scroll_cnt;
   logic [3:0]     off;
   logic [STW-1:0] step_cnt;
   logic [BLW-1:0] blink_cnt;
   logic           blink;

   logic       rise;
   logic       scan_wrap;
   logic       scroll_wrap;
   logic       last_step;
   logic       blink_wrap;
   logic [3:0] pos;
   logic [3:0] nib;
   logic       blank;

   assign rise        = disp_data_en & ~en_q;
   assign scan_wrap   = (scan_cnt == SCAN_MAX);
   assign scroll_wrap = (scroll_cnt == SCROLL_MAX);
   assign last_step   = (step_cnt == STEP_LAST);
   assign blink_wrap  = (blink_cnt == BLINK_MAX);
   assign busy        = (state == ST_SCROLL);

   function automatic logic [7:0] seg_of(input logic [3:0] d);
      logic [7:0] s;
      case (d)
         4'd0:    s = 8'hC0;
         4'd1:    s = 8'hF9;
         4'd2:    s = 8'hA4;
         4'd3:    s = 8'hB0;
         4'd4:    s = 8'h99;
         4'd5:    s = 8'h92;
         4'd6:    s = 8'h82;
         4'd7:    s = 8'hF8;
         4'd8:    s = 8'h80;
         4'd9:    s = 8'h90;
         default: s = 8'hFF;
      endcase
      return s;
   endfunction

   // Select the nibble (or blank) for the digit currently being scanned
   always_comb begin
      pos   = off + 4'd7 - {1'b0, idx};
      nib   = disp_data[{idx, 2'b00} +: 4];
      blank = 1'b0;
      if (state == ST_SCROLL) begin
         nib   = snap[{~pos[2:0], 2'b00} +: 4];
         blank = pos[3];
      end else if (edit_mode && (weishu == {1'b0, idx})) begin
         nib   = shuzi;
         blank = ~blink;
      end
   end

   // Delay the scroll enable for rising-edge detection
   always_ff @(posedge clk) begin
      if (rst) en_q <= 1'b0;
      else     en_q <= disp_data_en;
   end

   // Mode FSM, ID snapshot and scroll step timing
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_NORMAL;
         snap       <= '0;
         scroll_cnt <= '0;
         off        <= '0;
         step_cnt   <= '0;
      end else if (state == ST_NORMAL) begin
         if (rise) begin
            state <= ST_SCROLL;
            snap  <= disp_data;
         end
      end else if (scroll_wrap) begin
         scroll_cnt <= '0;
         if (last_step) begin
            state    <= ST_NORMAL;
            off      <= '0;
            step_cnt <= '0;
         end else begin
            off      <= off + 4'd1;
            step_cnt <= step_cnt + 1'b1;
         end
      end else begin
         scroll_cnt <= scroll_cnt + 1'b1;
      end
   end

   // Digit scan: hold each digit SCAN_DIV cycles, then move to the next
   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt <= '0;
         idx      <= '0;
      end else if (scan_wrap) begin
         scan_cnt <= '0;
         idx      <= idx + 3'd1;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
      end
   end

   // Cursor blink: free-runs in edit view, held on/cleared otherwise
   always_ff @(posedge clk) begin
      if (rst || !edit_mode) begin
         blink_cnt <= '0;
         blink     <= 1'b1;
      end else if (state == ST_NORMAL) begin
         if (blink_wrap) begin
            blink_cnt <= '0;
            blink     <= ~blink;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

   // Registered digit enable and segment outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         an  <= 8'hFF;
         seg <= 8'hFF;
      end else begin
         an  <= ~(8'h01 << idx);
         seg <= blank ? 8'hFF : seg_of(nib);
      end
   end

endmodule

// File: tb/tb_seg_scroll_disp.sv
// tb_seg_scroll_disp: scoreboard bench for seg_scroll_disp.
// Stimulus pushes per-edge expectations; a monitor pops and compares.
module tb_seg_scroll_disp;

   localparam int STEPS = 16 * 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] disp_data;
   logic        disp_data_en;
   logic        edit_mode;
   logic [3:0]  weishu;
   logic [3:0]  shuzi;
   logic [7:0]  an;
   logic [7:0]  seg;
   logic        busy;

   typedef struct {
      int         e;
      logic [7:0] an;
      logic [7:0] seg;
      logic       busy;
   } exp_t;

   exp_t        q[$];
   exp_t        cur;
   int          cyc = 0;
   int          n_tests = 0;
   int          n_fail = 0;
   int          r0 = 0;
   int          scroll_t = -1;
   int          edit_t = 0;
   logic [31:0] snap_v = '0;

   seg_scroll_disp #(
      .SCAN_DIV(4),
      .SCROLL_DIV(8),
      .BLINK_DIV(16),
      .SCROLL_LAPS(1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .disp_data(disp_data),
      .disp_data_en(disp_data_en),
      .edit_mode(edit_mode),
      .weishu(weishu),
      .shuzi(shuzi),
      .an(an),
      .seg(seg),
      .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] dec(input logic [3:0] d);
      case (d)
         4'd0:    return 8'hC0;
         4'd1:    return 8'hF9;
         4'd2:    return 8'hA4;
         4'd3:    return 8'hB0;
         4'd4:    return 8'h99;
         4'd5:    return 8'h92;
         4'd6:    return 8'h82;
         4'd7:    return 8'hF8;
         4'd8:    return 8'h80;
         4'd9:    return 8'h90;
         default: return 8'hFF;
      endcase
   endfunction

   // Expected outputs just after edge e, given inputs applied for edge e
   function automatic exp_t model(input int e);
      exp_t       x;
      int         idx;
      int         off;
      int         k;
      logic [3:0] d;
      logic       blank;
      x.e = e;
      if (rst) begin
         x.an   = 8'hFF;
         x.seg  = 8'hFF;
         x.busy = 1'b0;
         return x;
      end
      idx    = ((e - r0) >> 2) & 7;
      x.an   = ~(8'h01 << idx);
      x.busy = (scroll_t >= 0) && (e >= scroll_t) && (e < scroll_t + STEPS);
      blank  = 1'b0;
      d      = 4'd0;
      if (scroll_t >= 0 && e > scroll_t && e <= scroll_t + STEPS) begin
         off = ((e - 1 - scroll_t) >> 3) & 15;
         k   = (off + 7 - idx) & 15;
         if (k >= 8) blank = 1'b1;
         else        d = snap_v[4*(7-k) +: 4];
      end else if (edit_mode && int'(weishu) == idx) begin
         if ((((e - edit_t) >> 4) & 1) == 0) d = shuzi;
         else                                blank = 1'b1;
      end else begin
         d = disp_data[4*idx +: 4];
      end
      x.seg = blank ? 8'hFF : dec(d);
      return x;
   endfunction

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         q.push_back(model(cyc + 1));
         @(negedge clk);
      end
   endtask

   task automatic trigger();
      disp_data_en = 1'b1;
      scroll_t     = cyc + 1;
      snap_v       = disp_data;
      step(1);
      disp_data_en = 1'b0;
   endtask

   always @(posedge clk) begin
      #1;
      while (q.size() > 0 && q[0].e <= cyc) begin
         cur = q.pop_front();
         n_tests++;
         if (cur.e != cyc) begin
            n_fail++;
            $display("FAIL missed edge %0d at cycle %0d", cur.e, cyc);
         end else if (an !== cur.an || seg !== cur.seg || busy !== cur.busy) begin
            n_fail++;
            $display("FAIL edge %0d: an=%h seg=%h busy=%b, want an=%h seg=%h busy=%b",
                     cyc, an, seg, busy, cur.an, cur.seg, cur.busy);
         end
      end
   end

   initial begin
      rst          = 1'b1;
      disp_data    = 32'h1234_5678;
      disp_data_en = 1'b0;
      edit_mode    = 1'b0;
      weishu       = 4'd0;
      shuzi        = 4'd0;
      step(3);
      rst = 1'b0;
      r0  = cyc + 1;
      step(64);

      edit_mode = 1'b1;
      weishu    = 4'd2;
      shuzi     = 4'd9;
      edit_t    = cyc + 1;
      step(70);
      weishu = 4'd8;
      step(40);
      edit_mode = 1'b0;
      step(8);

      trigger();
      step(140);

      trigger();
      step(40);
      disp_data    = 32'h0;
      disp_data_en = 1'b1;
      step(1);
      disp_data_en = 1'b0;
      step(100);
      disp_data = 32'h1234_5678;
      step(8);

      disp_data_en = 1'b1;
      scroll_t     = cyc + 1;
      snap_v       = disp_data;
      step(300);
      disp_data_en = 1'b0;
      step(5);
      trigger();
      step(140);

      trigger();
      step(40);
      rst      = 1'b1;
      scroll_t = -1;
      step(2);
      rst = 1'b0;
      r0  = cyc + 1;
      step(40);

      repeat (3) @(posedge clk);
      #2;
      if (q.size() > 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: %0d expectations left, want 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
